// File: rtl/pwm_peripheral.sv
// Register-write sink driving 16 pins as static-low, static-high or prescaled 256-step PWM.
// The duty cycle is double-buffered and reloaded only at the period boundary.
module pwm_peripheral #(
    parameter int unsigned PRESCALE = 13,
    parameter int unsigned MAX_ADDR = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       wr_en,
    input  logic [6:0] wr_addr,
    input  logic [7:0] wr_data,
    output logic       wr_ack,
    output logic       wr_err,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic       period_start
);

    localparam logic [15:0] TICK_LAST = 16'(PRESCALE - 1);
    localparam logic [6:0]  ADDR_LAST = 7'(MAX_ADDR);

    logic [15:0] en_out_q, en_out_d;
    logic [15:0] en_pwm_q, en_pwm_d;
    logic [7:0]  duty_q, duty_d;
    logic [7:0]  duty_active_q, duty_active_d;
    logic [15:0] tick_cnt_q, tick_cnt_d;
    logic [7:0]  pwm_cnt_q, pwm_cnt_d;
    logic [15:0] pins_q, pins_d;
    logic        ack_q, ack_d;
    logic        err_q, err_d;
    logic        pstart_q, pstart_d;

    logic addr_ok;
    logic tick;
    logic boundary;
    logic pwm_level;

    always_comb begin
        en_out_d = en_out_q;
        en_pwm_d = en_pwm_q;
        duty_d   = duty_q;
        addr_ok  = (wr_addr <= ADDR_LAST);
        ack_d    = wr_en & addr_ok;
        err_d    = wr_en & ~addr_ok;
        if (wr_en && addr_ok) begin
            case (wr_addr)
                7'd0:    en_out_d[7:0]  = wr_data;
                7'd1:    en_out_d[15:8] = wr_data;
                7'd2:    en_pwm_d[7:0]  = wr_data;
                7'd3:    en_pwm_d[15:8] = wr_data;
                7'd4:    duty_d         = wr_data;
                default: ;
            endcase
        end
    end

    always_comb begin
        tick       = (tick_cnt_q == TICK_LAST);
        tick_cnt_d = tick ? '0 : tick_cnt_q + 16'd1;
        pwm_cnt_d  = tick ? pwm_cnt_q + 8'd1 : pwm_cnt_q;
        boundary   = tick && (pwm_cnt_q == 8'hFF);
        pstart_d   = boundary;
        // Shadow load samples duty_q before any same-edge write lands in it.
        duty_active_d = boundary ? duty_q : duty_active_q;
        pwm_level  = (duty_active_q == 8'hFF) || (pwm_cnt_q < duty_active_q);
        pins_d     = en_out_q & (~en_pwm_q | {16{pwm_level}});
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            en_out_q      <= '0;
            en_pwm_q      <= '0;
            duty_q        <= '0;
            duty_active_q <= '0;
            tick_cnt_q    <= '0;
            pwm_cnt_q     <= '0;
            pins_q        <= '0;
            ack_q         <= 1'b0;
            err_q         <= 1'b0;
            pstart_q      <= 1'b0;
        end else begin
            en_out_q      <= en_out_d;
            en_pwm_q      <= en_pwm_d;
            duty_q        <= duty_d;
            duty_active_q <= duty_active_d;
            tick_cnt_q    <= tick_cnt_d;
            pwm_cnt_q     <= pwm_cnt_d;
            pins_q        <= pins_d;
            ack_q         <= ack_d;
            err_q         <= err_d;
            pstart_q      <= pstart_d;
        end
    end

    assign wr_ack       = ack_q;
    assign wr_err       = err_q;
    assign uo_out       = pins_q[7:0];
    assign uio_out      = pins_q[15:8];
    assign period_start = pstart_q;

endmodule

// File: tb/tb_pwm_peripheral.sv
// Directed bench for pwm_peripheral at PRESCALE=2 (512-clock PWM period).
module tb_pwm_peripheral;

    logic       clk = 1'b0;
    logic       rst;
    logic       wr_en;
    logic [6:0] wr_addr;
    logic [7:0] wr_data;
    logic       wr_ack;
    logic       wr_err;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic       period_start;

    int tests = 0;
    int fails = 0;

    pwm_peripheral #(.PRESCALE(2), .MAX_ADDR(4)) dut (
        .clk(clk),
        .rst(rst),
        .wr_en(wr_en),
        .wr_addr(wr_addr),
        .wr_data(wr_data),
        .wr_ack(wr_ack),
        .wr_err(wr_err),
        .uo_out(uo_out),
        .uio_out(uio_out),
        .period_start(period_start)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wr(input logic [6:0] a, input logic [7:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        step();
        wr_en = 1'b0;
    endtask

    task automatic wait_period();
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while (period_start !== 1'b1 && n < 2000);
        check("period_start_timeout", 16'(period_start), 16'd1);
    endtask

    task automatic run_periods(input int wk, input logic [7:0] wd,
                               output int h0, output int h1, output int h2);
        h0 = 0; h1 = 0; h2 = 0;
        for (int k = 1; k <= 1536; k++) begin
            if (k == wk) begin
                wr_en = 1'b1; wr_addr = 7'd4; wr_data = wd;
            end
            step();
            wr_en = 1'b0;
            if (uo_out[0]) begin
                if (k <= 512) h0++;
                else if (k <= 1024) h1++;
                else h2++;
            end
            if (k % 512 == 0) check("shadow_pstart", 16'(period_start), 16'd1);
        end
    endtask

    initial begin
        int h0, h1, h2;
        rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        #2;
        check("reset_uo", 16'(uo_out), 16'h00);
        check("reset_uio", 16'(uio_out), 16'h00);
        check("reset_ack", 16'(wr_ack), 16'd0);
        step();
        rst = 1'b0;

        for (int i = 0; i < 100; i++) begin
            step();
            check("idle_uo", 16'(uo_out), 16'h00);
            check("idle_uio", 16'(uio_out), 16'h00);
            check("idle_ackerr", 16'({wr_ack, wr_err}), 16'd0);
            check("idle_pstart", 16'(period_start), 16'd0);
        end

        // Back-to-back writes to 0x00 then 0x01.
        wr_en = 1'b1; wr_addr = 7'd0; wr_data = 8'hA5;
        step();
        check("wr0_ack", 16'(wr_ack), 16'd1);
        check("wr0_uo_latency", 16'(uo_out), 16'h00);
        wr_addr = 7'd1; wr_data = 8'h3C;
        step();
        wr_en = 1'b0;
        check("wr1_ack", 16'(wr_ack), 16'd1);
        check("wr0_uo", 16'(uo_out), 16'hA5);
        check("wr1_uio_latency", 16'(uio_out), 16'h00);
        step();
        check("wr1_ack_end", 16'(wr_ack), 16'd0);
        check("wr1_uio", 16'(uio_out), 16'h3C);

        wr(7'd5, 8'hFF);
        check("err5_err", 16'(wr_err), 16'd1);
        check("err5_ack", 16'(wr_ack), 16'd0);
        step();
        check("err5_err_end", 16'(wr_err), 16'd0);
        check("err5_outs", {uio_out, uo_out}, 16'h3CA5);
        wr(7'h7F, 8'hFF);
        check("err7f_err", 16'(wr_err), 16'd1);
        check("err7f_ack", 16'(wr_ack), 16'd0);
        step();
        check("err7f_outs", {uio_out, uo_out}, 16'h3CA5);

        // Asynchronous reset between clock edges.
        #2 rst = 1'b1;
        #1;
        check("async_rst_outs", {uio_out, uo_out}, 16'h0000);
        step();
        rst = 1'b0;
        step();
        check("post_rst_outs", {uio_out, uo_out}, 16'h0000);

        wr(7'd0, 8'h01);
        wr(7'd2, 8'h01);
        wr(7'd4, 8'h80);
        wait_period();
        for (int k = 1; k <= 1024; k++) begin
            step();
            check("pwm80_level", 16'(uo_out[0]), 16'((((k - 1) % 512) < 256) ? 1 : 0));
            check("pwm80_pstart", 16'(period_start), 16'((k % 512 == 0) ? 1 : 0));
        end

        wr(7'd4, 8'h00);
        wait_period();
        h0 = 0;
        for (int k = 1; k <= 1540; k++) begin
            step();
            if (uo_out[0] !== 1'b0) h0++;
        end
        check("duty00_highs", 16'(h0), 16'd0);

        wr(7'd4, 8'hFF);
        wait_period();
        h0 = 0;
        for (int k = 1; k <= 1540; k++) begin
            step();
            if (uo_out[0] !== 1'b1) h0++;
        end
        check("dutyFF_lows", 16'(h0), 16'd0);

        wr(7'd4, 8'h40);
        wait_period();
        run_periods(100, 8'hC0, h0, h1, h2);
        check("mid_p0", 16'(h0), 16'd128);
        check("mid_p1", 16'(h1), 16'd384);
        check("mid_p2", 16'(h2), 16'd384);
        run_periods(512, 8'h40, h0, h1, h2);
        check("bnd_p0", 16'(h0), 16'd384);
        check("bnd_p1", 16'(h1), 16'd384);
        check("bnd_p2", 16'(h2), 16'd128);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
